// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4-bit add/sub unit with a one-entry result slot.
// Optional signed-overflow output res_ovf is built only when ADDSUB_OVF_EN is defined.
module addsub_arbiter #(
   parameter int RR_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req0_m,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic       req1_m,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic       res_cout,
   output logic       res_id
`ifdef ADDSUB_OVF_EN
   ,
   output logic       res_ovf
`endif
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0] state;
   logic       last_served;
   logic       slot_free;
   logic       grant_id;
   logic       take;
   logic       accept;
   logic [3:0] sel_a;
   logic [3:0] sel_b;
   logic       sel_m;
   logic [3:0] op_b;
   logic [4:0] sum;
`ifdef ADDSUB_OVF_EN
   logic       ovf;
`endif

   assign res_valid = (state == FULL);
   assign slot_free = (state == EMPTY) || res_ready;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid)
         grant_id = ~last_served;
      else if (req1_valid)
         grant_id = 1'b1;
   end

   // Reset gates the readies combinationally so nothing offered during reset is taken.
   assign take       = !rst && slot_free;
   assign req0_ready = take && req0_valid && (grant_id == 1'b0);
   assign req1_ready = take && req1_valid && (grant_id == 1'b1);
   assign accept     = req0_ready || req1_ready;

   assign sel_a = grant_id ? req1_a : req0_a;
   assign sel_b = grant_id ? req1_b : req0_b;
   assign sel_m = grant_id ? req1_m : req0_m;
   assign op_b  = sel_b ^ {4{sel_m}};
   assign sum   = {1'b0, sel_a} + {1'b0, op_b} + {4'b0000, sel_m};

`ifdef ADDSUB_OVF_EN
   assign ovf = sel_m ? ((sel_a[3] != sel_b[3]) && (sum[3] != sel_a[3]))
                      : ((sel_a[3] == sel_b[3]) && (sum[3] != sel_a[3]));
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: result registers are reset too, because their reset value is architecturally visible.
         state       <= EMPTY;
         res_data    <= 4'd0;
         res_cout    <= 1'b0;
         res_id      <= 1'b0;
         last_served <= (RR_INIT == 0);
`ifdef ADDSUB_OVF_EN
         res_ovf     <= 1'b0;
`endif
      end else if (accept) begin
         state       <= FULL;
         res_data    <= sum[3:0];
         res_cout    <= sum[4];
         res_id      <= grant_id;
         last_served <= grant_id;
`ifdef ADDSUB_OVF_EN
         res_ovf     <= ovf;
`endif
      end else if (res_ready) begin
         // Drain without refill: payload keeps its last value, only the slot empties.
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized traffic against
// an arithmetic reference model. res_ovf is checked only when ADDSUB_OVF_EN is defined.
module tb_addsub_arbiter;

   localparam int RR_INIT = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req0_m;
   logic [3:0] req0_a, req0_b;
   logic       req1_valid, req1_ready, req1_m;
   logic [3:0] req1_a, req1_b;
   logic       res_valid, res_ready, res_cout, res_id;
   logic [3:0] res_data;
`ifdef ADDSUB_OVF_EN
   logic       res_ovf;
`endif

   addsub_arbiter #(.RR_INIT(RR_INIT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_cout(res_cout), .res_id(res_id)
`ifdef ADDSUB_OVF_EN
      , .res_ovf(res_ovf)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit       exp_valid = 0;
   bit [3:0] exp_data = 0;
   bit       exp_cout = 0, exp_id = 0, exp_ovf = 0;
   int       last = 1 - RR_INIT;
   bit       exp_r0, exp_r1;
   logic     obs_r0, obs_r1;

   // One clock cycle: drive inputs, sample readies, advance DUT and model together.
   task automatic cycle(input logic r, input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic m0, input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                        input logic m1, input logic rr);
      int g, a, b, m, r5, sa, sb, sr;
      @(negedge clk);
      rst = r; res_ready = rr;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_m = m0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_m = m1;
      #1;
      g = -1;
      if (!r && (!exp_valid || rr)) begin
         if (v0 && v1) g = 1 - last;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      exp_r0 = (g == 0);
      exp_r1 = (g == 1);
      obs_r0 = req0_ready;
      obs_r1 = req1_ready;
      @(posedge clk);
      #1;
      if (r) begin
         exp_valid = 0; exp_data = 0; exp_cout = 0; exp_id = 0; exp_ovf = 0;
         last = 1 - RR_INIT;
      end else if (g >= 0) begin
         a = (g == 1) ? int'(a1) : int'(a0);
         b = (g == 1) ? int'(b1) : int'(b0);
         m = (g == 1) ? int'(m1) : int'(m0);
         r5 = (m == 1) ? a - b + 16 : a + b;
         exp_data = r5[3:0];
         exp_cout = r5[4];
         sa = (a > 7) ? a - 16 : a;
         sb = (b > 7) ? b - 16 : b;
         sr = (m == 1) ? sa - sb : sa + sb;
         exp_ovf = (sr > 7) || (sr < -8);
         exp_id = g[0];
         exp_valid = 1;
         last = g;
      end else if (rr) begin
         exp_valid = 0;
      end
   endtask

   task automatic test_reset();
      cycle(1, 1, 4'd1, 4'd1, 0, 1, 4'd2, 4'd2, 0, 0);
      n_cmp++;
      if ({obs_r0, obs_r1} !== 2'b00) begin
         n_bad++; $display("FAIL reset_readies: got %b want 00", {obs_r0, obs_r1});
      end
      n_cmp++;
      if ({res_valid, res_data, res_cout, res_id} !== 7'b0) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 0000000", {res_valid, res_data, res_cout, res_id});
      end
`ifdef ADDSUB_OVF_EN
      n_cmp++;
      if (res_ovf !== 1'b0) begin
         n_bad++; $display("FAIL reset_ovf: got %b want 0", res_ovf);
      end
`endif
   endtask

   task automatic test_add();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 4'd5, 4'd3, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
         n_bad++; $display("FAIL add_ready: got %b%b want 10", obs_r0, obs_r1);
      end
      n_cmp++;
      if ({res_valid, res_data, res_cout, res_id} !== {1'b1, 4'd8, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_5_3: got v%b d%0d c%b id%b want v1 d8 c0 id0", res_valid, res_data, res_cout, res_id);
      end
   endtask

   task automatic test_sub();
      cycle(0, 0, 0, 0, 0, 1, 4'd3, 4'd5, 1, 1);
      n_cmp++;
      if ({res_valid, res_data, res_cout, res_id} !== {1'b1, 4'd14, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL sub_3_5: got v%b d%0d c%b id%b want v1 d14 c0 id1", res_valid, res_data, res_cout, res_id);
      end
      cycle(0, 0, 0, 0, 0, 1, 4'd5, 4'd3, 1, 1);
      n_cmp++;
      if ({res_valid, res_data, res_cout, res_id} !== {1'b1, 4'd2, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL sub_5_3: got v%b d%0d c%b id%b want v1 d2 c1 id1", res_valid, res_data, res_cout, res_id);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if ({res_valid, res_data, res_cout, res_id} !== {1'b0, 4'd2, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL drain_hold: got v%b d%0d c%b id%b want v0 d2 c1 id1", res_valid, res_data, res_cout, res_id);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 4'($urandom), 4'($urandom), 1'($urandom), 1, 4'($urandom), 4'($urandom), 1'($urandom), 1);
         n_cmp++;
         if ({res_valid, res_id} !== {1'b1, 1'(i % 2)} || res_data !== exp_data || res_cout !== exp_cout) begin
            n_bad++; $display("FAIL b2b_%0d: got v%b id%b d%0d c%b want v1 id%0d d%0d c%b",
                              i, res_valid, res_id, res_data, res_cout, i % 2, exp_data, exp_cout);
         end
      end
   endtask

   task automatic test_backpressure();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 4'd5, 4'd3, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 4'd2, 4'd2, 0, 1, 4'd6, 4'd1, 0, 0);
         n_cmp++;
         if ({obs_r0, obs_r1} !== 2'b00 || {res_valid, res_data, res_cout, res_id} !== {1'b1, 4'd8, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL stall_%0d: got r%b%b v%b d%0d c%b id%b want r00 v1 d8 c0 id0",
                              i, obs_r0, obs_r1, res_valid, res_data, res_cout, res_id);
         end
      end
      cycle(0, 1, 4'd2, 4'd2, 0, 1, 4'd6, 4'd1, 0, 1);
      n_cmp++;
      if ({obs_r0, obs_r1} !== 2'b01 || {res_valid, res_data, res_id} !== {1'b1, 4'd7, 1'b1}) begin
         n_bad++; $display("FAIL stall_release: got r%b%b v%b d%0d id%b want r01 v1 d7 id1",
                           obs_r0, obs_r1, res_valid, res_data, res_id);
      end
   endtask

   task automatic test_reset_full();
      cycle(0, 1, 4'd1, 4'd1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 4'd4, 4'd4, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({obs_r0, obs_r1} !== 2'b00 || res_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_full: got r%b%b v%b want r00 v0", obs_r0, obs_r1, res_valid);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_no_accept: got v%b want v0", res_valid);
      end
      cycle(0, 1, 4'd1, 4'd2, 0, 1, 4'd3, 4'd4, 0, 1);
      n_cmp++;
      if (res_valid !== 1'b1 || res_id !== 1'(RR_INIT)) begin
         n_bad++; $display("FAIL reset_first_grant: got v%b id%b want v1 id%0d", res_valid, res_id, RR_INIT);
      end
   endtask

   task automatic test_ovf();
      cycle(0, 1, 4'd7, 4'd1, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (res_data !== 4'd8) begin
         n_bad++; $display("FAIL ovf_add_data: got %0d want 8", res_data);
      end
`ifdef ADDSUB_OVF_EN
      n_cmp++;
      if (res_ovf !== 1'b1) begin
         n_bad++; $display("FAIL ovf_add: got %b want 1", res_ovf);
      end
`endif
      cycle(0, 1, 4'd8, 4'd1, 1, 0, 0, 0, 0, 1);
      n_cmp++;
      if (res_data !== 4'd7) begin
         n_bad++; $display("FAIL ovf_sub_data: got %0d want 7", res_data);
      end
`ifdef ADDSUB_OVF_EN
      n_cmp++;
      if (res_ovf !== 1'b1) begin
         n_bad++; $display("FAIL ovf_sub: got %b want 1", res_ovf);
      end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 39) == 0),
               1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0));
         n_cmp++;
         if ({obs_r0, obs_r1} !== {exp_r0, exp_r1}) begin
            n_bad++; $display("FAIL rand_ready_%0d: got %b%b want %b%b", i, obs_r0, obs_r1, exp_r0, exp_r1);
         end
         n_cmp++;
         if ({res_valid, res_data, res_cout, res_id} !== {exp_valid, exp_data, exp_cout, exp_id}) begin
            n_bad++; $display("FAIL rand_out_%0d: got v%b d%0d c%b id%b want v%b d%0d c%b id%b", i,
                              res_valid, res_data, res_cout, res_id, exp_valid, exp_data, exp_cout, exp_id);
         end
`ifdef ADDSUB_OVF_EN
         n_cmp++;
         if (res_ovf !== exp_ovf) begin
            n_bad++; $display("FAIL rand_ovf_%0d: got %b want %b", i, res_ovf, exp_ovf);
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b1; res_ready = 1'b0;
      req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_m = 1'b0;
      req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_m = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_reset_full();
      test_ovf();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, which selects the requester that gets priority at the first contention after reset (0 or 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 offers an operation.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_a and req0_b, inputs, 4 bits each: requester 0 operands.
REQ-007 The block SHALL have port req0_m, input, 1 bit: requester 0 mode (0 = add, 1 = subtract).
REQ-008 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_m, identical to the requester 0 ports, for requester 1.
REQ-009 The block SHALL have port res_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port res_data, output, 4 bits: the 4-bit sum or difference.
REQ-012 The block SHALL have port res_cout, output, 1 bit: carry out (for subtract, 1 = no borrow).
REQ-013 The block SHALL have port res_id, output, 1 bit: index of the requester that produced the result.
REQ-014 The block SHALL have port res_ovf, output, 1 bit: signed overflow; this port SHALL exist only when ADDSUB_OVF_EN is defined.

Function
REQ-015 The block SHALL contain one shared add/sub datapath: {cout,data} = A + (B XOR {4{M}}) + M, 5-bit result, with no wider intermediate truncation.
REQ-016 The output slot state SHALL be EMPTY (res_valid=0) or FULL (res_valid=1).
REQ-017 The slot SHALL be free in a cycle when it is EMPTY, or when it is FULL and res_ready=1.
REQ-018 Grant rules, evaluated combinationally each cycle:
- When the slot is free and exactly one reqN_valid=1, that requester SHALL be granted.
- When both are valid, the requester other than the last-served one SHALL be granted.
- Before any grant after reset, requester RR_INIT SHALL be treated as not last-served.
REQ-019 reqN_ready SHALL be 1 only for the granted requester, only when its valid=1 and the slot is free; reqN_ready SHALL NOT depend on the requester's own ready.
REQ-020 Acceptance SHALL happen at the edge where valid&ready=1. On that edge the block SHALL:
- register res_data, res_cout, res_id (and res_ovf);
- set res_valid=1;
- record the granted index as last-served.
REQ-021 Latency SHALL be exactly 1 cycle from acceptance to res_valid=1.
REQ-022 With res_ready held at 1, throughput SHALL be one result per cycle.
REQ-023 Simultaneous drain and accept in one cycle SHALL keep res_valid=1 and load the new result.
REQ-024 While FULL and res_ready=0, all res_* outputs SHALL hold stable and both reqN_ready SHALL be 0.
REQ-025 On drain with no acceptance in the same cycle, the slot SHALL go EMPTY; res_data, res_cout, res_id and res_ovf SHALL keep their last values.
REQ-026 The last-served pointer SHALL change only on acceptance; idle cycles and backpressure SHALL NOT alter it.

Reset
REQ-027 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-028 After an edge with rst=1:
- res_valid=0, res_data=0, res_cout=0, res_id=0, res_ovf=0;
- the last-served pointer SHALL be set to 1-RR_INIT.
REQ-029 A reset asserted while FULL SHALL discard the held result without it being presented again; a request offered during reset SHALL NOT be accepted.

Configuration
REQ-030 With ADDSUB_OVF_EN defined:
- res_ovf SHALL be registered with each result;
- for add, res_ovf = (A[3]==B[3]) & (data[3]!=A[3]);
- for subtract, res_ovf = (A[3]!=B[3]) & (data[3]!=A[3]).
REQ-031 Without ADDSUB_OVF_EN, the res_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 req0 only, A=5, B=3, M=0 -> one cycle later res_valid=1, res_data=8, res_cout=0, res_id=0.
REQ-033 req1, A=3, B=5, M=1 -> res_data=14, res_cout=0, res_id=1; then A=5, B=3, M=1 -> res_data=2, res_cout=1.
REQ-034 Both valid continuously, res_ready=1, RR_INIT=0 -> res_id sequence 0,1,0,1 with res_valid=1 every cycle after the first.
REQ-035 res_ready=0 for 3 cycles while FULL with both requesters valid:
- -> res_* stable and both readies 0;
- on res_ready=1 -> the next request is accepted in that same cycle.
REQ-036 rst=1 for one cycle while FULL with req0 valid -> next cycle res_valid=0 and no acceptance; with both requesters valid afterwards, requester RR_INIT is granted first.
REQ-037 A=7, B=1, M=0 and A=8, B=1, M=1:
- with ADDSUB_OVF_EN -> res_data=8 then 7, res_ovf=1 both times;
- without ADDSUB_OVF_EN -> same res_data and no res_ovf port.
